// File: rtl/alu_cmd_sequencer.sv
// Command stage in front of the ALU result MUX: registers operands/select, waits
// a settle time, captures the selected MUX output and hands it downstream.
module alu_cmd_sequencer #(
  parameter int DATA_W        = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [1:0]        mux_s,
  output logic [DATA_W-1:0] mux_a,
  output logic [DATA_W-1:0] mux_b,
  input  logic [DATA_W-1:0] mux_y1,
  input  logic [DATA_W-1:0] mux_y2,
  input  logic [DATA_W-1:0] mux_y3,
  input  logic [DATA_W-1:0] mux_y4,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_op,
  output logic              res_zero,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        mux_s_q, mux_s_d;
  logic [DATA_W-1:0] mux_a_q, mux_a_d;
  logic [DATA_W-1:0] mux_b_q, mux_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [1:0]        res_op_q, res_op_d;
  logic              res_zero_q, res_zero_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic [DATA_W-1:0] y_sel_s;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b0}});
  endfunction

  // Pick the MUX output addressed by the registered select.
  always_comb begin
    case (mux_s_q)
      2'b00:   y_sel_s = mux_y1;
      2'b01:   y_sel_s = mux_y2;
      2'b10:   y_sel_s = mux_y3;
      2'b11:   y_sel_s = mux_y4;
      default: y_sel_s = mux_y1;
    endcase
  end

  // Next-state and datapath update for the IDLE/SETTLE/RESULT sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mux_s_d     = mux_s_q;
    mux_a_d     = mux_a_q;
    mux_b_d     = mux_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_zero_d  = res_zero_q;
    op_count_d  = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mux_s_d = cmd_op;
          mux_a_d = cmd_a;
          mux_b_d = cmd_b;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          res_data_d  = y_sel_s;
          res_op_d    = mux_s_q;
          res_zero_d  = is_zero(y_sel_s);
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        // Unreachable encoding: drop any result and return to a safe idle.
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mux_s_q     <= 2'd0;
      mux_a_q     <= {DATA_W{1'b0}};
      mux_b_q     <= {DATA_W{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {DATA_W{1'b0}};
      res_op_q    <= 2'd0;
      res_zero_q  <= 1'b1;
      op_count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mux_s_q     <= mux_s_d;
      mux_a_q     <= mux_a_d;
      mux_b_q     <= mux_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_zero_q  <= res_zero_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign mux_s     = mux_s_q;
  assign mux_a     = mux_a_q;
  assign mux_b     = mux_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_zero  = res_zero_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: instance 0 uses defaults, instance 1 uses
// SETTLE_CYCLES=3 / CNT_W=2; both drive an add/sub/and/or MUX stub.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n     [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_op    [2];
  logic [3:0] cmd_a     [2];
  logic [3:0] cmd_b     [2];
  logic [1:0] mux_s     [2];
  logic [3:0] mux_a     [2];
  logic [3:0] mux_b     [2];
  logic [3:0] y1 [2], y2 [2], y3 [2], y4 [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic [3:0] res_data  [2];
  logic [1:0] res_op    [2];
  logic       res_zero  [2];
  logic [7:0] oc0;
  logic [1:0] oc1;
  logic [7:0] op_count_w [2];

  int compared = 0;
  int mismatched = 0;
  int exp_cnt [2];
  logic [1:0] last_s [2];
  logic [3:0] last_a [2];
  logic [3:0] last_b [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign op_count_w[0] = oc0;
  assign op_count_w[1] = {6'd0, oc1};

  for (genvar g = 0; g < 2; g++) begin : g_stub
    assign y1[g] = mux_a[g] + mux_b[g];
    assign y2[g] = mux_a[g] - mux_b[g];
    assign y3[g] = mux_a[g] & mux_b[g];
    assign y4[g] = mux_a[g] | mux_b[g];
  end

  alu_cmd_sequencer dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .mux_s(mux_s[0]), .mux_a(mux_a[0]), .mux_b(mux_b[0]),
    .mux_y1(y1[0]), .mux_y2(y2[0]), .mux_y3(y3[0]), .mux_y4(y4[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .res_op(res_op[0]), .res_zero(res_zero[0]), .op_count(oc0)
  );

  alu_cmd_sequencer #(.DATA_W(4), .SETTLE_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .mux_s(mux_s[1]), .mux_a(mux_a[1]), .mux_b(mux_b[1]),
    .mux_y1(y1[1]), .mux_y2(y2[1]), .mux_y3(y3[1]), .mux_y4(y4[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .res_op(res_op[1]), .res_zero(res_zero[1]), .op_count(oc1)
  );

  // Reference: the result the downstream should see for a command.
  function automatic logic [3:0] ref_y(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 16;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return 4'(r % 16);
  endfunction

  function automatic int settle_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int cnt_mod(input int i);
    return (i == 1) ? 4 : 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input int i);
    chk("rst_cmd_ready", 32'(cmd_ready[i]), 32'd1);
    chk("rst_res_valid", 32'(res_valid[i]), 32'd0);
    chk("rst_mux_s", 32'(mux_s[i]), 32'd0);
    chk("rst_mux_a", 32'(mux_a[i]), 32'd0);
    chk("rst_mux_b", 32'(mux_b[i]), 32'd0);
    chk("rst_res_data", 32'(res_data[i]), 32'd0);
    chk("rst_res_op", 32'(res_op[i]), 32'd0);
    chk("rst_res_zero", 32'(res_zero[i]), 32'd1);
    chk("rst_op_count", 32'(op_count_w[i]), 32'd0);
    exp_cnt[i] = 0;
    last_s[i] = 2'd0; last_a[i] = 4'd0; last_b[i] = 4'd0;
  endtask

  task automatic do_op(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input int idle, input int hold);
    int lat;
    logic [3:0] e;
    cmd_valid[i] = 1'b0;
    repeat (idle) begin
      tick();
      chk("idle_ready", 32'(cmd_ready[i]), 32'd1);
      chk("idle_mux_s", 32'(mux_s[i]), 32'(last_s[i]));
      chk("idle_mux_a", 32'(mux_a[i]), 32'(last_a[i]));
    end
    cmd_op[i] = op; cmd_a[i] = a; cmd_b[i] = b; cmd_valid[i] = 1'b1;
    res_ready[i] = (hold == 0);
    tick();
    cmd_valid[i] = 1'b0;
    chk("acc_mux_s", 32'(mux_s[i]), 32'(op));
    chk("acc_mux_a", 32'(mux_a[i]), 32'(a));
    chk("acc_mux_b", 32'(mux_b[i]), 32'(b));
    chk("acc_cmd_ready", 32'(cmd_ready[i]), 32'd0);
    last_s[i] = op; last_a[i] = a; last_b[i] = b;
    lat = 0;
    while (res_valid[i] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    e = ref_y(op, a, b);
    chk("latency", 32'(lat), 32'(settle_of(i)));
    chk("res_data", 32'(res_data[i]), 32'(e));
    chk("res_op", 32'(res_op[i]), 32'(op));
    chk("res_zero", 32'(res_zero[i]), 32'(e == 4'd0));
    res_ready[i] = 1'b0;
    repeat (hold) begin
      tick();
      chk("hold_valid", 32'(res_valid[i]), 32'd1);
      chk("hold_data", 32'(res_data[i]), 32'(e));
      chk("hold_zero", 32'(res_zero[i]), 32'(e == 4'd0));
      chk("hold_ready", 32'(cmd_ready[i]), 32'd0);
      chk("hold_mux_s", 32'(mux_s[i]), 32'(op));
    end
    res_ready[i] = 1'b1;
    tick();
    res_ready[i] = 1'b0;
    exp_cnt[i] = (exp_cnt[i] + 1) % cnt_mod(i);
    chk("hs_valid", 32'(res_valid[i]), 32'd0);
    chk("hs_count", 32'(op_count_w[i]), 32'(exp_cnt[i]));
    chk("hs_ready", 32'(cmd_ready[i]), 32'd1);
    chk("hs_data_kept", 32'(res_data[i]), 32'(e));
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_op[i] = 2'd0;
      cmd_a[i] = 4'd0; cmd_b[i] = 4'd0; res_ready[i] = 1'b0;
    end
    // Reset asserted between clock edges must act immediately.
    #3;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #1;
    reset_chk(0);
    reset_chk(1);
    tick(); tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();

    do_op(0, 2'b01, 4'b1011, 4'b0011, 0, 0);
    chk("single_count", 32'(op_count_w[0]), 32'd1);

    // Backpressure on an all-zero result, with a second command held while busy.
    cmd_op[0] = 2'b10; cmd_a[0] = 4'b1100; cmd_b[0] = 4'b0011; cmd_valid[0] = 1'b1;
    tick();
    chk("bp_mux_s", 32'(mux_s[0]), 32'd2);
    cmd_op[0] = 2'b00; cmd_a[0] = 4'b0001; cmd_b[0] = 4'b0001;
    tick();
    chk("bp_valid", 32'(res_valid[0]), 32'd1);
    chk("bp_data", 32'(res_data[0]), 32'd0);
    chk("bp_zero", 32'(res_zero[0]), 32'd1);
    repeat (5) begin
      tick();
      chk("bp_hold_valid", 32'(res_valid[0]), 32'd1);
      chk("bp_hold_data", 32'(res_data[0]), 32'd0);
      chk("bp_hold_zero", 32'(res_zero[0]), 32'd1);
      chk("bp_hold_ready", 32'(cmd_ready[0]), 32'd0);
      chk("busy_mux_s", 32'(mux_s[0]), 32'd2);
      chk("busy_mux_a", 32'(mux_a[0]), 32'hC);
    end
    res_ready[0] = 1'b1;
    tick();
    res_ready[0] = 1'b0;
    chk("bp_count", 32'(op_count_w[0]), 32'd2);
    chk("bp_idle_ready", 32'(cmd_ready[0]), 32'd1);
    tick();
    cmd_valid[0] = 1'b0;
    chk("late_mux_s", 32'(mux_s[0]), 32'd0);
    chk("late_mux_a", 32'(mux_a[0]), 32'd1);
    chk("late_mux_b", 32'(mux_b[0]), 32'd1);
    tick();
    chk("late_data", 32'(res_data[0]), 32'd2);
    chk("late_valid", 32'(res_valid[0]), 32'd1);
    res_ready[0] = 1'b1;
    tick();
    res_ready[0] = 1'b0;
    chk("late_count", 32'(op_count_w[0]), 32'd3);
    exp_cnt[0] = 3; last_s[0] = 2'd0; last_a[0] = 4'd1; last_b[0] = 4'd1;

    // Longer settle and a 2-bit counter that wraps 1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      do_op(1, 2'b11, 4'b0101, 4'b1010, 0, k % 2);
      chk("wrap_count", 32'(op_count_w[1]), 32'((k + 1) % 4));
    end

    // Reset mid-SETTLE discards the pending result.
    cmd_op[1] = 2'b01; cmd_a[1] = 4'd7; cmd_b[1] = 4'd2; cmd_valid[1] = 1'b1;
    tick();
    cmd_valid[1] = 1'b0;
    tick();
    #2;
    rst_n[1] = 1'b0;
    #1;
    reset_chk(1);
    tick();
    rst_n[1] = 1'b1;
    lat = 0;
    repeat (4) begin
      tick();
      if (res_valid[1] !== 1'b0) lat++;
    end
    chk("post_rst_no_valid", 32'(lat), 32'd0);
    chk("post_rst_count", 32'(op_count_w[1]), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready[1]), 32'd1);

    // Randomized traffic on both configurations.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 2; i++) begin
        do_op(i, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
